// File: rtl/serial_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_fifo_pkg
//  Purpose  : Shared definitions for the serial_tx_fifo transmitter: frame
//             FSM encoding and 8N1 frame constants.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_tx_fifo_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic STOP_LVL  = 1'b1;   // also the idle line level
    localparam logic START_LVL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/serial_tx_fifo_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : byte_fifo
//  Purpose  : Byte-wide synchronous FIFO, first-word-fall-through read.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             wr_en/wr_data - write strobe and byte (ignored while full)
//             rd_en         - pop the head entry (ignored while empty)
//             rd_data       - head entry, valid whenever empty = 0
//             full, empty   - status from the registered count
//             count         - entries stored (ADDR_W+1 bits)
//  Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_ok, rd_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Full blocks a write even when a pop happens on the same edge.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps modulo depth
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_fifo
//  Purpose  : Buffered 8N1 serial transmitter. Bytes are queued in a FIFO and
//             shifted out LSB first, one start bit and one stop bit per frame.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             tx_data      - byte to queue
//             new_tx_data  - write strobe, one byte per cycle
//             tx_busy      - FIFO full, writes are dropped
//             block        - host hold-off, checked only at frame start
//             tx           - registered serial line, idle high
//             overflow     - sticky, a write was attempted while full
//             fifo_count   - bytes currently queued
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx_fifo
    import serial_tx_fifo_pkg::*;
#(
    parameter int CLK_PER_BIT = 100,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        tx_data,
    input  logic              new_tx_data,
    output logic              tx_busy,
    input  logic              block,
    output logic              tx,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_count
);

    localparam int               CNT_W      = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;

    logic             pop;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             baud_done;

    byte_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (new_tx_data),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tx_busy   = fifo_full;
    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (new_tx_data & fifo_full);

        case (state_q)
            IDLE: begin
                tx_d = STOP_LVL;
                if (!fifo_empty && !block) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    tx_d    = START_LVL;
                    baud_d  = CNT_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    baud_d    = CNT_RELOAD;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = CNT_RELOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = STOP_LVL;
                        state_d = STOP;
                    end else begin
                        // shift_q[0] is the bit just sent; [1] is next.
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when possible.
                    if (!fifo_empty && !block) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        tx_d    = START_LVL;
                        baud_d  = CNT_RELOAD;
                        state_d = START;
                    end else begin
                        tx_d    = STOP_LVL;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                tx_d    = STOP_LVL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= STOP_LVL;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_fifo
//  Purpose  : Directed self-checking bench for serial_tx_fifo
//             (CLK_PER_BIT = 4, ADDR_W = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_fifo;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tx_data = 8'h00;
    logic          new_tx_data = 1'b0;
    logic          block = 1'b0;
    logic          tx_busy;
    logic          tx;
    logic          overflow;
    logic [AW:0]   fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    serial_tx_fifo #(
        .CLK_PER_BIT (CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .block       (block),
        .tx          (tx),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge on which tx fell for the start bit. Checks
    // every cycle of the 10-bit frame and returns just after the edge that
    // ends the stop bit. Optionally raises block during data bit 2.
    task automatic frame(input string tag, input logic [7:0] b, input bit blk_mid);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("%s_bit%0d_cyc%0d", tag, i, c), {31'd0, tx}, {31'd0, f[i]});
                if (blk_mid && i == 3 && c == 0) block = 1'b1;
                tick();
            end
        end
    endtask

    // Bounded wait for a start bit.
    task automatic wait_low(input string tag, input int limit);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_start_seen"}, {31'd0, tx}, 32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_tx",       {31'd0, tx},          32'd1);
        chk("rst_busy",     {31'd0, tx_busy},     32'd0);
        chk("rst_overflow", {31'd0, overflow},    32'd0);
        chk("rst_count",    {29'd0, fifo_count},  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_tx", {31'd0, tx}, 32'd1);

        // ---------------- single byte B1 ----------------
        tx_data = 8'hB1; new_tx_data = 1'b1;
        tick();                                   // edge N: write
        new_tx_data = 1'b0;
        chk("b1_count_after_wr", {29'd0, fifo_count}, 32'd1);
        chk("b1_tx_still_idle",  {31'd0, tx},         32'd1);
        tick();                                   // edge N+1: start bit
        chk("b1_count_after_pop", {29'd0, fifo_count}, 32'd0);
        frame("b1", 8'hB1, 1'b0);
        chk("b1_idle_after", {31'd0, tx}, 32'd1);
        tick();
        chk("b1_idle_after2", {31'd0, tx}, 32'd1);
        chk("b1_count_end",   {29'd0, fifo_count}, 32'd0);

        // ---------------- back-to-back 08, 00 ----------------
        tx_data = 8'h08; new_tx_data = 1'b1;
        tick();
        tx_data = 8'h00;
        tick();                                   // pop 08 + write 00
        new_tx_data = 1'b0;
        chk("b2b_count", {29'd0, fifo_count}, 32'd1);
        frame("b2b_08", 8'h08, 1'b0);
        frame("b2b_00", 8'h00, 1'b0);             // no gap: 80 cycles total
        chk("b2b_idle_after", {31'd0, tx}, 32'd1);
        tick();
        chk("b2b_idle_after2", {31'd0, tx}, 32'd1);

        // ---------------- fill and overflow ----------------
        block = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tx_data = 8'(k); new_tx_data = 1'b1;
            tick();
            chk($sformatf("fill_count_%0d", k), {29'd0, fifo_count}, k);
            chk($sformatf("fill_busy_%0d", k), {31'd0, tx_busy}, (k == 4) ? 32'd1 : 32'd0);
        end
        chk("fill_ovf_before", {31'd0, overflow}, 32'd0);
        tx_data = 8'h05;
        tick();                                   // dropped
        new_tx_data = 1'b0;
        chk("fill_ovf_set",   {31'd0, overflow},   32'd1);
        chk("fill_count_5",   {29'd0, fifo_count}, 32'd4);
        chk("fill_tx_held",   {31'd0, tx},         32'd1);
        block = 1'b0;
        wait_low("fill", 5);
        chk("fill_busy_clear", {31'd0, tx_busy}, 32'd0);
        frame("fill_01", 8'h01, 1'b0);
        frame("fill_02", 8'h02, 1'b0);
        frame("fill_03", 8'h03, 1'b0);
        frame("fill_04", 8'h04, 1'b0);
        chk("fill_idle_after",  {31'd0, tx},         32'd1);
        tick();
        chk("fill_idle_after2", {31'd0, tx},         32'd1);
        chk("fill_count_end",   {29'd0, fifo_count}, 32'd0);
        chk("fill_ovf_sticky",  {31'd0, overflow},   32'd1);

        // ---------------- block mid-frame ----------------
        tx_data = 8'hA5; new_tx_data = 1'b1;
        tick();
        tx_data = 8'h5A;
        tick();                                   // pop A5 + queue 5A
        new_tx_data = 1'b0;
        frame("blk_A5", 8'hA5, 1'b1);             // block rises in DATA
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("blk_held_%0d", k), {31'd0, tx}, 32'd1);
            tick();
        end
        chk("blk_count_held", {29'd0, fifo_count}, 32'd1);
        block = 1'b0;
        tick();                                   // next edge starts 5A
        frame("blk_5A", 8'h5A, 1'b0);
        chk("blk_idle_after", {31'd0, tx}, 32'd1);
        tick();

        // ---------------- reset mid-frame ----------------
        tx_data = 8'hFF; new_tx_data = 1'b1;
        tick();
        tx_data = 8'hAA;
        tick();                                   // start bit of FF (edge E)
        tx_data = 8'hBB;
        tick();                                   // E+1
        new_tx_data = 1'b0;
        chk("rmf_count_queued", {29'd0, fifo_count}, 32'd2);
        for (int k = 0; k < 16; k++) tick();      // E+17: data bit 3
        chk("rmf_bit3", {31'd0, tx}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmf_tx",       {31'd0, tx},         32'd1);
        chk("rmf_count",    {29'd0, fifo_count}, 32'd0);
        chk("rmf_overflow", {31'd0, overflow},   32'd0);
        chk("rmf_busy",     {31'd0, tx_busy},    32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rmf_quiet_%0d", k), {31'd0, tx}, 32'd1);
        end
        tx_data = 8'h55; new_tx_data = 1'b1;
        tick();
        new_tx_data = 1'b0;
        tick();
        frame("rmf_55", 8'h55, 1'b0);
        chk("rmf_idle_after", {31'd0, tx}, 32'd1);
        tick();

        // ---------------- simultaneous write and pop ----------------
        block = 1'b1;
        tx_data = 8'hC3; new_tx_data = 1'b1;
        tick();
        chk("sim_count_pre", {29'd0, fifo_count}, 32'd1);
        block = 1'b0;
        tx_data = 8'h3C;
        tick();                                   // pop C3 + write 3C
        new_tx_data = 1'b0;
        chk("sim_count_same", {29'd0, fifo_count}, 32'd1);
        frame("sim_C3", 8'hC3, 1'b0);
        frame("sim_3C", 8'h3C, 1'b0);
        chk("sim_idle_after", {31'd0, tx},         32'd1);
        chk("sim_count_end",  {29'd0, fifo_count}, 32'd0);
        chk("sim_ovf_clear",  {31'd0, overflow},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
- UART-style transmitter and the far end of the `tx_data`/`new_tx_data`/`tx_busy` byte interface driven by the message printer.
- Accepts bytes into a small FIFO and serialises each one onto the `tx` line as 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Sits between the command/response logic and the board's serial pin.
- Supports host back-pressure through `block`.

Parameters:
- CLK_PER_BIT, 100, clock cycles per serial bit (50 MHz / 500 kbaud); legal range ≥ 2.
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W = 16 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tx_data  in  8  byte to send
- new_tx_data  in  1  write strobe; one byte per cycle while high
- tx_busy  out  1  high = FIFO full, write will be dropped
- block  in  1  host flow control; high = do not start a new frame
- tx  out  1  serial line, idle high, registered
- overflow  out  1  sticky; set on a write attempted while `tx_busy`
- fifo_count  out  ADDR_W+1  bytes currently stored

Behaviour:
- Interface:
  - One clock.
  - Reset is synchronous and active-high.
  - Port names are `clk` and `rst`.
- Reset values (all taken on the clock edge where `rst` = 1):
  - `tx` = 1, `tx_busy` = 0, `overflow` = 0, `fifo_count` = 0.
  - FSM = IDLE, baud counter = 0, bit index = 0.
- FIFO:
  - Write is accepted when `new_tx_data` = 1 and count < depth.
  - `tx_busy` = (count == depth), combinational from the registered count.
  - A write while `tx_busy` = 1 is discarded and sets `overflow`.
  - A write and a pop on the same edge are both performed; count is unchanged.
  - When full, a same-cycle pop does NOT allow the write, because `tx_busy` is already high.
  - Pointers wrap modulo depth.
  - `overflow` clears only on `rst`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - If count > 0 and `block` = 0: pop head into the shift register, `tx` <= 0, baud counter <= CLK_PER_BIT-1, go to START.
    - Otherwise `tx` <= 1.
  - START:
    - When the baud counter reaches 0: `tx` <= shift[0], bit index <= 0, reload the counter, go to DATA.
  - DATA:
    - Each time the counter reaches 0: shift right and drive the next bit.
    - After bit 7 completes: `tx` <= 1, reload, go to STOP.
  - STOP:
    - When the counter reaches 0: if count > 0 and `block` = 0, pop and go straight to START with `tx` <= 0 (no idle gap).
    - Otherwise go to IDLE.
- Bit timing:
  - Every bit is exactly CLK_PER_BIT cycles.
  - A frame is exactly 10·CLK_PER_BIT cycles.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE drives `tx` low after edge N+1.
- `block`:
  - Sampled only at a frame start.
  - Asserting it mid-frame never truncates the current frame.
  - Bytes keep accumulating in the FIFO while it is high.
- Reset mid-frame:
  - `tx` returns to 1 on the reset edge.
  - The FIFO is emptied and the partial byte is discarded.
- Arithmetic:
  - The baud counter is sized $clog2(CLK_PER_BIT).
  - The bit index is 3 bits.
  - `fifo_count` is ADDR_W+1 bits, so full is distinguishable from empty.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE = 0, START = 1, DATA = 2, STOP = 3).
  - Constants DATA_BITS = 8 and STOP_LVL = 1'b1.
- One sub-module, `byte_fifo`:
  - Parameter ADDR_W.
  - Ports `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`.
  - Read data is first-word-fall-through.
- The top level holds the baud counter, shift register, FSM and `overflow`.

Test Plan (CLK_PER_BIT = 4, ADDR_W = 2 for speed unless noted):
- Single byte: write 8'hB1 once.
  - `tx` goes low 2 edges later.
  - Per-bit sequence is 0,1,0,0,0,1,1,0,1,1, each level held 4 cycles, then idle high.
  - `fifo_count` returns to 0.
- Back-to-back: write 8'h08 then 8'h00 on consecutive cycles.
  - Two frames with no idle cycle between stop and next start.
  - Total low-to-final-high span is 80 cycles.
- Fill and overflow: hold `block` = 1 and write 5 bytes 8'h01..8'h05.
  - `tx_busy` = 1 after the 4th write.
  - The 5th byte is dropped and `overflow` = 1.
  - Release `block`: 01,02,03,04 are transmitted in order.
- `block` mid-frame: assert `block` during the DATA state of byte 8'hA5 with 8'h5A queued.
  - A5 completes fully.
  - 5A is held until `block` falls, then starts on the next edge.
- Reset mid-frame: pulse `rst` during bit 3 of 8'hFF with 2 bytes queued.
  - `tx` = 1 on the next cycle; count = 0, `overflow` = 0.
  - The next write of 8'h55 transmits cleanly.
- Simultaneous write/pop: with 1 byte queued, issue a write on the exact edge the FSM pops.
  - `fifo_count` stays 1.
  - Both bytes are transmitted in order.
